// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
//   byte_valid/byte_data/byte_ready : valid/ready byte stream into the loader
//   mem_we/mem_waddr/mem_wdata      : instruction memory write port out of the loader
// master: the stream source / memory side. slave: the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them into a WORDS x 32 instruction store, optionally NOP-filling
// the whole store first. Holds the core while loading.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load_start        one-cycle load request (ignored while busy)
//   load_base         byte start address, word aligned (bits [1:0] ignored)
//   load_len          word count, 0..WORDS; larger values raise err
//   load_clear        NOP-fill the whole store before receiving
//   bus (slave)       byte stream in, memory write port out
//   cpu_hold, busy    high while not idle
//   done              one-cycle pulse at the end of a load
//   err               sticky length error, cleared by the next accepted load_start
module imem_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WORDS    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-2:0] load_len,
  input  logic              load_clear,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned LEN_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RECV, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [IDX_W-1:0]  cidx_q, cidx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Byte offset bits of the base address are deliberately dropped.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^load_base[1:0];

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      widx_q       <= '0;
      cidx_q       <= '0;
      rem_q        <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      cidx_q       <= cidx_d;
      rem_q        <= rem_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they can be registered.
  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    cidx_d       = cidx_q;
    rem_d        = rem_q;
    bcnt_d       = bcnt_q;
    word_d       = word_q;
    err_d        = err_q;
    byte_ready_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          err_d = 1'b0;
          if (load_len > LEN_W'(WORDS)) begin
            err_d = 1'b1;
          end else begin
            widx_d = load_base[ADDR_W-1:2];
            rem_d  = load_len;
            bcnt_d = '0;
            if (load_clear) begin
              state_d     = CLEAR;
              cidx_d      = '0;
              mem_we_d    = 1'b1;
              mem_waddr_d = '0;
              mem_wdata_d = NOP_WORD;
            end else if (load_len == '0) begin
              state_d = DONE;
            end else begin
              state_d      = RECV;
              byte_ready_d = 1'b1;
            end
          end
        end
      end

      CLEAR: begin
        if (cidx_q == LAST_IDX) begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            state_d      = RECV;
            byte_ready_d = 1'b1;
          end
        end else begin
          cidx_d      = cidx_q + IDX_W'(1);
          mem_we_d    = 1'b1;
          mem_waddr_d = {cidx_d, 2'b00};
          mem_wdata_d = NOP_WORD;
        end
      end

      RECV: begin
        byte_ready_d = 1'b1;
        if (bus.byte_valid && byte_ready_q) begin
          // Shift in from the top: after four bytes the first one sits in [7:0].
          word_d = {bus.byte_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            mem_we_d     = 1'b1;
            mem_waddr_d  = {widx_q, 2'b00};
            mem_wdata_d  = word_d;
          end
        end
      end

      WRITE: begin
        widx_d = (widx_q == LAST_IDX) ? '0 : widx_q + IDX_W'(1);
        rem_d  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy           = busy_q;
  assign cpu_hold       = busy_q;   // hold spans exactly the non-idle states
  assign done           = done_q;
  assign err            = err_q;
  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives loads and byte streams, logs memory
// writes, and compares against hand-computed addresses and words.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic [7:0] load_base;
  logic [6:0] load_len;
  logic       load_clear;
  logic       cpu_hold, busy, done, err;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_clear (load_clear),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Write / accept log, sampled on the falling edge.
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          last_we_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.byte_valid && bus.byte_ready) n_acc++;
    if (bus.mem_we) begin
      wa.push_back(bus.mem_waddr);
      wd.push_back(bus.mem_wdata);
      wc.push_back(cyc);
      last_we_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    n_acc  = 0;
    n_done = 0;
  endtask

  task automatic check_wr(input string tag, input int i, input logic [7:0] addr, input logic [31:0] data);
    if (i < wa.size()) begin
      check({tag, "_addr"}, 32'(wa[i]), 32'(addr));
      check({tag, "_data"}, wd[i], data);
    end else begin
      check({tag, "_missing"}, 32'(wa.size()), 32'(i + 1));
    end
  endtask

  // Pulse load_start for one cycle; called and returns at posedge+1.
  task automatic start_load(input logic [7:0] base, input logic [6:0] len, input logic clr);
    bus.byte_valid = 1'b0;
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    load_clear = clr;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Offer one byte until accepted, then optionally idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    while (!bus.byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(v[7:0], gaps ? int'($urandom_range(1, 3)) : 0);
      v = v >> 8;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(busy), 32'(0));
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    load_start = 1'b0; load_base = '0; load_len = '0; load_clear = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 0);
    check("rst_hold",  32'(cpu_hold), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(err), 0);
    check("rst_ready", 32'(bus.byte_ready), 0);
    check("rst_we",    32'(bus.mem_we), 0);
    check("rst_waddr", 32'(bus.mem_waddr), 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two words, valid held high, no ninth accept
    clear_log();
    start_load(8'h10, 7'd2, 1'b0);
    check("t1_hold_on", 32'(cpu_hold), 1);
    send_word(32'h0800_0293, 1'b0);
    send_word(32'h0400_0313, 1'b0);
    check("t1_hold_mid", 32'(cpu_hold), 1);
    wait_idle();
    check("t1_nwr", 32'(wa.size()), 2);
    check_wr("t1_w0", 0, 8'h10, 32'h0800_0293);
    check_wr("t1_w1", 1, 8'h14, 32'h0400_0313);
    check("t1_acc", 32'(n_acc), 8);
    check("t1_ndone", 32'(n_done), 1);
    check("t1_done_lat", 32'(done_cyc - last_we_cyc), 1);
    check("t1_hold_off", 32'(cpu_hold), 0);

    // Clear pass then one word at 0x00
    clear_log();
    start_load(8'h00, 7'd1, 1'b1);
    send_word(32'h5634_12B7, 1'b0);
    wait_idle();
    check("t2_nwr", 32'(wa.size()), 65);
    bad = 0;
    if (wa.size() == 65) begin
      for (int i = 0; i < 64; i++)
        if (wa[i] != 8'(i * 4) || wd[i] != 32'h0000_0013) bad++;
      if (wc[63] - wc[0] != 63) bad++;
    end else begin
      bad = 99;
    end
    check("t2_clear_seq", 32'(bad), 0);
    check_wr("t2_word", 64, 8'h00, 32'h5634_12B7);

    // Index wrap 0xFC -> 0x00
    clear_log();
    start_load(8'hFC, 7'd2, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    wait_idle();
    check("t3_nwr", 32'(wa.size()), 2);
    check_wr("t3_w0", 0, 8'hFC, 32'h1122_3344);
    check_wr("t3_w1", 1, 8'h00, 32'h5566_7788);

    // Unaligned base is word aligned
    clear_log();
    start_load(8'h13, 7'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_idle();
    check_wr("t4_w0", 0, 8'h10, 32'hDEAD_BEEF);

    // Zero length
    clear_log();
    start_load(8'h40, 7'd0, 1'b0);
    wait_idle();
    check("t5_nwr", 32'(wa.size()), 0);
    check("t5_ndone", 32'(n_done), 1);

    // Over-length error, then cleared by a valid load
    clear_log();
    start_load(8'h00, 7'd65, 1'b0);
    @(negedge clk);
    check("t6_err", 32'(err), 1);
    check("t6_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", 32'(err), 1);
    check("t6_nwr", 32'(wa.size()), 0);
    check("t6_ndone", 32'(n_done), 0);
    @(posedge clk); #1;
    start_load(8'h20, 7'd1, 1'b0);
    check("t6_err_clr", 32'(err), 0);
    send_word(32'h00A0_0093, 1'b0);
    wait_idle();
    check_wr("t6_w0", 0, 8'h20, 32'h00A0_0093);

    // Valid gaps give the same writes
    clear_log();
    start_load(8'h10, 7'd2, 1'b0);
    send_word(32'h0800_0293, 1'b1);
    send_word(32'h0400_0313, 1'b1);
    wait_idle();
    check("t7_nwr", 32'(wa.size()), 2);
    check_wr("t7_w0", 0, 8'h10, 32'h0800_0293);
    check_wr("t7_w1", 1, 8'h14, 32'h0400_0313);
    check("t7_acc", 32'(n_acc), 8);

    // Reset in the middle of a word
    clear_log();
    start_load(8'h10, 7'd1, 1'b0);
    send_byte(8'h93, 0);
    send_byte(8'h02, 0);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t8_busy", 32'(busy), 0);
    check("t8_hold", 32'(cpu_hold), 0);
    check("t8_ready", 32'(bus.byte_ready), 0);
    check("t8_we", 32'(bus.mem_we), 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t8_nwr", 32'(wa.size()), 0);
    start_load(8'h08, 7'd1, 1'b0);
    send_word(32'h0000_0513, 1'b0);
    wait_idle();
    check("t8_nwr2", 32'(wa.size()), 1);
    check_wr("t8_w0", 0, 8'h08, 32'h0000_0513);

    // load_start while busy is ignored
    clear_log();
    start_load(8'h10, 7'd2, 1'b0);
    send_byte(8'h93, 0);
    send_byte(8'h02, 0);
    start_load(8'h80, 7'd70, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    send_word(32'h0400_0313, 1'b0);
    wait_idle();
    check("t9_nwr", 32'(wa.size()), 2);
    check_wr("t9_w0", 0, 8'h10, 32'h0800_0293);
    check_wr("t9_w1", 1, 8'h14, 32'h0400_0313);
    check("t9_err", 32'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: loads programs into a writable 64 x 32-bit instruction store.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into little-endian 32-bit instruction words.
- Drives the memory write port and holds the core in stall while loading.
- Optionally pre-fills the whole store with NOPs before loading, so unloaded words match the power-on image.

Parameters:
ADDR_W, 8, byte-address width of the instruction memory port
WORDS, 64, number of 32-bit words in the instruction store (index width = ADDR_W-2)
NOP_WORD, 32'h00000013, fill value used by the clear pass (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  single-cycle request to begin a load; ignored while busy
load_base  in  8  byte start address; bits [1:0] ignored (word aligned)
load_len  in  7  number of words to load, 0..64
load_clear  in  1  when high at load_start, NOP-fill all words before receiving
byte_valid  in  1  byte_data valid
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  instruction memory write enable
mem_waddr  out  8  byte write address, bits [1:0] always 0
mem_wdata  out  32  write data
cpu_hold  out  1  stall/hold request to the core
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of a successful load
err  out  1  sticky length error, cleared by the next accepted load_start

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, mem_waddr=0, mem_wdata=0. Partial word, counters and index cleared. No write is issued.
- States: IDLE, CLEAR, RECV, WRITE, DONE. All outputs are registered.
- IDLE, load_start=1:
  - Latch widx = load_base[7:2], remaining = load_len. Clear err.
  - load_len > 64: err=1 next cycle, stay IDLE, no writes, busy stays 0.
  - load_len = 0: go to DONE with no writes. If load_clear=1, the clear pass still runs first.
  - load_clear=1: go to CLEAR with clear index = 0. Otherwise go to RECV with byte count = 0.
- CLEAR:
  - One write per cycle for 64 cycles: mem_we=1, mem_waddr={cidx,2'b00}, mem_wdata=NOP_WORD, cidx = 0..63.
  - After cidx = 63: go to RECV, or to DONE if remaining = 0.
  - byte_ready=0 throughout.
- RECV:
  - byte_ready=1. A byte transfers only when byte_valid & byte_ready. Gaps in byte_valid are allowed.
  - Transfer k (k = 0..3) is placed in bits [8k+7:8k], little-endian.
  - On the 4th transfer, go to WRITE. byte_ready is 0 in the following cycle, so there is no 5th accept.
- WRITE:
  - Exactly one cycle with mem_we=1, mem_waddr={widx,2'b00}, mem_wdata=assembled word.
  - widx increments modulo 64, so index 63 wraps to 0. remaining decrements.
  - Go to DONE when remaining reaches 0, otherwise back to RECV.
- DONE: done=1 for one cycle, then IDLE.
- cpu_hold: 1 from the cycle after an accepted load_start through the DONE cycle. 0 in IDLE.
- mem_we is 0 in every state except CLEAR and WRITE.
- load_start while busy: ignored, no effect on state or err.
- Throughput: one word per 5 cycles at best (4 RECV accepts + 1 WRITE).

Test Plan:
- base=0x10, len=2, clear=0; bytes 93 02 00 08 13 03 00 04 with valid held high -> writes 0x08000293@0x10 and 0x04000313@0x14; done pulse one cycle after 2nd write; cpu_hold high throughout; no 9th byte accepted.
- clear=1, base=0x00, len=1 -> 64 writes of 0x00000013 to 0x00..0xFC on consecutive cycles, then the received word @0x00; total mem_we pulses = 65.
- base=0xFC, len=2 -> writes @0xFC then @0x00 (wrap). base=0x13 -> first write @0x10.
- len=0, clear=0 -> done pulse, zero mem_we pulses. len=65 -> err=1, busy=0, no writes. A following valid load_start clears err.
- Random valid gaps (1-3 idle cycles between bytes) -> identical write sequence. Reset asserted after 2 bytes -> all outputs 0 immediately, no write; a fresh load then completes correctly.
- load_start pulsed during RECV with a different base -> ignored; original addresses written.
